// File: rtl/vc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_pkg
// Description : Shared encodings and helpers for the qspi arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vc_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_I_FILL = 3'd1;
    localparam logic [2:0] c_ST_D_PUSH = 3'd2;
    localparam logic [2:0] c_ST_D_PULL = 3'd3;
    localparam logic [2:0] c_ST_ERR    = 3'd4;

    localparam logic c_STREAM_I = 1'b0;
    localparam logic c_STREAM_D = 1'b1;

    function automatic int tag_width(input int pa, input int line_length);
        return pa - $clog2(line_length);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : arb_watchdog
// Description : Transfer watchdog; flags a transfer that ran TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // Saturates at the limit so it can never wrap back below it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = run && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/qspi_arb.sv
`default_nettype none
// ============================================================================
// Module      : qspi_arb
// Description : Round-robin arbiter sharing the qspi engine between caches.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_arb
    import vc_pkg::*;
#(
    parameter  int PA          = 22,
    parameter  int LINE_LENGTH = 4,
    parameter  int TIMEOUT     = 255,
    localparam int TW          = tag_width(PA, LINE_LENGTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_pull,
    input  logic [TW-1:0] i_tag,
    input  logic          d_push,
    input  logic          d_pull,
    input  logic [TW-1:0] d_tag,
    input  logic          q_done,
    input  logic          fault_clr,
    output logic          q_req,
    output logic          q_i_d,
    output logic          q_write,
    output logic          q_mem,
    output logic [TW-1:0] q_paddr,
    output logic          i_done,
    output logic          d_done,
    output logic          busy,
    output logic          bus_fault
);

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic          w_grant;
    logic          w_grant_i;
    logic          w_in_xfer;
    logic          w_expired;
    logic          w_d_cand;
    logic [TW-1:0] w_tag_sel;

    logic          r_last;
    logic [TW-1:0] r_paddr;
    logic          r_i_d;
    logic          r_write;
    logic          r_mem;
    logic          r_i_done;
    logic          r_d_done;

    assign w_d_cand  = d_push | d_pull;
    assign w_in_xfer = (r_state == c_ST_I_FILL) || (r_state == c_ST_D_PUSH) ||
                       (r_state == c_ST_D_PULL);
    assign w_tag_sel = w_grant_i ? i_tag : d_tag;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_grant),
        .run     (w_in_xfer),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ties go to the stream that did not win last time.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_i    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (i_pull && (!w_d_cand || (r_last == c_STREAM_D))) begin
                    w_grant      = 1'b1;
                    w_grant_i    = 1'b1;
                    w_state_next = c_ST_I_FILL;
                end else if (w_d_cand) begin
                    w_grant      = 1'b1;
                    w_state_next = d_push ? c_ST_D_PUSH : c_ST_D_PULL;
                end
            end
            c_ST_I_FILL, c_ST_D_PUSH, c_ST_D_PULL: begin
                if (q_done) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_expired) begin
                    w_state_next = c_ST_ERR;
                end
            end
            c_ST_ERR: begin
                if (fault_clr) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        q_req     = w_in_xfer;
        busy      = (r_state != c_ST_IDLE);
        bus_fault = (r_state == c_ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last   <= c_STREAM_D;
            r_paddr  <= '0;
            r_i_d    <= 1'b0;
            r_write  <= 1'b0;
            r_mem    <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            r_i_done <= (r_state == c_ST_I_FILL) && q_done;
            r_d_done <= ((r_state == c_ST_D_PUSH) || (r_state == c_ST_D_PULL)) && q_done;
            if (w_grant) begin
                r_last  <= w_grant_i ? c_STREAM_I : c_STREAM_D;
                r_paddr <= w_tag_sel;
                r_i_d   <= w_grant_i;
                r_write <= !w_grant_i && d_push;
                r_mem   <= &w_tag_sel[TW-1:TW-8];
            end
        end
    end

    assign q_paddr = r_paddr;
    assign q_i_d   = r_i_d;
    assign q_write = r_write;
    assign q_mem   = r_mem;
    assign i_done  = r_i_done;
    assign d_done  = r_d_done;

endmodule
`default_nettype wire
